// File: rtl/wb_retire_unit_if.sv
// Bundle between the memory stage and the retire unit: retire handshake, write-back inputs, read ports, redirect and status.
// master = upstream pipeline/bench, slave = wb_retire_unit.
interface wb_retire_unit_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [3:0]      in_wb_sel;
    logic [AW-1:0]   in_wb_addr;
    logic            in_rf_wen;
    logic [XLEN-1:0] in_alu_out;
    logic [XLEN-1:0] in_mem_rdata;
    logic [1:0]      in_mem_off;
    logic [XLEN-1:0] in_csr_rdata;
    logic            in_br_flg;
    logic            in_jmp_flg;
    logic            in_trap;
    logic [XLEN-1:0] in_br_target;
    logic [XLEN-1:0] in_trap_vector;

    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [63:0]     instret;
    logic            exit;

    modport master (
        output in_valid, in_pc, in_wb_sel, in_wb_addr, in_rf_wen,
               in_alu_out, in_mem_rdata, in_mem_off, in_csr_rdata,
               in_br_flg, in_jmp_flg, in_trap, in_br_target, in_trap_vector,
               rs1_addr, rs2_addr,
        input  in_ready, rs1_data, rs2_data,
               redirect_valid, redirect_pc, instret, exit
    );

    modport slave (
        input  in_valid, in_pc, in_wb_sel, in_wb_addr, in_rf_wen,
               in_alu_out, in_mem_rdata, in_mem_off, in_csr_rdata,
               in_br_flg, in_jmp_flg, in_trap, in_br_target, in_trap_vector,
               rs1_addr, rs2_addr,
        output in_ready, rs1_data, rs2_data,
               redirect_valid, redirect_pc, instret, exit
    );
endinterface

// File: rtl/wb_retire_unit.sv
// Write-back/retire stage: load extraction, register file commit, redirect pulse, retire counter, sticky exit.
// Latency: RF write and redirect visible next cycle (same-cycle reads via bypass); in_ready = !exit, no other stall.
module wb_retire_unit #(
    parameter int              XLEN    = 32,
    parameter int              NREG    = 32,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(32'h0000_0800),
    parameter logic [XLEN-1:0] EXIT_PC = XLEN'(32'hFFFF_FF00)
) (
    input logic              clk,
    input logic              rst_n,
    wb_retire_unit_if.slave  bus
);
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [3:0] SEL_ALU   = 4'd0;
    localparam logic [3:0] SEL_MEMB  = 4'd1;
    localparam logic [3:0] SEL_MEMBU = 4'd2;
    localparam logic [3:0] SEL_MEMH  = 4'd3;
    localparam logic [3:0] SEL_MEMHU = 4'd4;
    localparam logic [3:0] SEL_MEMW  = 4'd5;
    localparam logic [3:0] SEL_PC4   = 4'd6;
    localparam logic [3:0] SEL_CSR   = 4'd7;

    logic [XLEN-1:0] rf_q [NREG];
    logic            redir_vld_q, redir_vld_d;
    logic [XLEN-1:0] redir_pc_q,  redir_pc_d;
    logic [63:0]     instret_q,   instret_d;
    logic            exit_q,      exit_d;

    logic            retire;
    logic            rf_we;
    logic [XLEN-1:0] byte_sh;
    logic [XLEN-1:0] half_sh;
    logic [XLEN-1:0] wb_data;

    assign bus.in_ready = !exit_q;
    assign retire       = bus.in_valid && !exit_q;
    assign rf_we        = retire && bus.in_rf_wen && (bus.in_wb_addr != '0);

    // Halfword lanes are selected by offset bit 1 only, so a misaligned
    // halfword offset folds back onto its aligned lane.
    assign byte_sh = bus.in_mem_rdata >> {bus.in_mem_off, 3'b000};
    assign half_sh = bus.in_mem_rdata >> {bus.in_mem_off[1], 4'b0000};

    always_comb begin
        wb_data = bus.in_alu_out;
        case (bus.in_wb_sel)
            SEL_MEMB:  wb_data = {{(XLEN-8){byte_sh[7]}},   byte_sh[7:0]};
            SEL_MEMBU: wb_data = {{(XLEN-8){1'b0}},         byte_sh[7:0]};
            SEL_MEMH:  wb_data = {{(XLEN-16){half_sh[15]}}, half_sh[15:0]};
            SEL_MEMHU: wb_data = {{(XLEN-16){1'b0}},        half_sh[15:0]};
            SEL_MEMW:  wb_data = bus.in_mem_rdata;
            SEL_PC4:   wb_data = bus.in_pc + XLEN'(4);
            SEL_CSR:   wb_data = bus.in_csr_rdata;
            SEL_ALU:   wb_data = bus.in_alu_out;
            default:   wb_data = bus.in_alu_out;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= (i == 2) ? SP_INIT : '0;
            end
        end else if (rf_we) begin
            rf_q[bus.in_wb_addr] <= wb_data;
        end
    end

    // Bypass lets the decode stage see a value retiring in this very cycle.
    assign bus.rs1_data = (bus.rs1_addr == '0)                       ? '0      :
                          (rf_we && (bus.rs1_addr == bus.in_wb_addr)) ? wb_data :
                                                                        rf_q[bus.rs1_addr];
    assign bus.rs2_data = (bus.rs2_addr == '0)                       ? '0      :
                          (rf_we && (bus.rs2_addr == bus.in_wb_addr)) ? wb_data :
                                                                        rf_q[bus.rs2_addr];

    always_comb begin
        redir_vld_d = 1'b0;
        redir_pc_d  = redir_pc_q;
        instret_d   = instret_q;
        exit_d      = exit_q;
        if (retire) begin
            instret_d = instret_q + 64'd1;
            if (bus.in_pc == EXIT_PC) begin
                exit_d = 1'b1;
            end
            if (bus.in_br_flg) begin
                redir_vld_d = 1'b1;
                redir_pc_d  = bus.in_br_target;
            end else if (bus.in_jmp_flg) begin
                redir_vld_d = 1'b1;
                redir_pc_d  = bus.in_alu_out;
            end else if (bus.in_trap) begin
                redir_vld_d = 1'b1;
                redir_pc_d  = bus.in_trap_vector;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redir_vld_q <= 1'b0;
            redir_pc_q  <= '0;
            instret_q   <= '0;
            exit_q      <= 1'b0;
        end else begin
            redir_vld_q <= redir_vld_d;
            redir_pc_q  <= redir_pc_d;
            instret_q   <= instret_d;
            exit_q      <= exit_d;
        end
    end

    assign bus.redirect_valid = redir_vld_q;
    assign bus.redirect_pc    = redir_pc_q;
    assign bus.instret        = instret_q;
    assign bus.exit           = exit_q;

endmodule

// File: tb/tb_wb_retire_unit.sv
// Directed bench for wb_retire_unit: loads, x0, bypass, PC+4 wrap, redirect priority, exit, async reset.
module tb_wb_retire_unit;
    localparam logic [3:0] S_ALU = 4'd0, S_MEMB = 4'd1, S_MEMBU = 4'd2, S_MEMH = 4'd3,
                           S_MEMHU = 4'd4, S_MEMW = 4'd5, S_PC4 = 4'd6, S_CSR = 4'd7;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    wb_retire_unit_if #(.XLEN(32), .NREG(32)) bus ();

    wb_retire_unit #(
        .XLEN(32), .NREG(32), .SP_INIT(32'h0000_0800), .EXIT_PC(32'hFFFF_FF00)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.in_valid       = 1'b0;
        bus.in_pc          = '0;
        bus.in_wb_sel      = '0;
        bus.in_wb_addr     = '0;
        bus.in_rf_wen      = 1'b0;
        bus.in_alu_out     = '0;
        bus.in_mem_rdata   = '0;
        bus.in_mem_off     = '0;
        bus.in_csr_rdata   = '0;
        bus.in_br_flg      = 1'b0;
        bus.in_jmp_flg     = 1'b0;
        bus.in_trap        = 1'b0;
        bus.in_br_target   = '0;
        bus.in_trap_vector = '0;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [3:0] sel, input logic [4:0] addr,
                         input logic wen, input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [1:0] off);
        clear_inputs();
        bus.in_valid     = 1'b1;
        bus.in_pc        = pc;
        bus.in_wb_sel    = sel;
        bus.in_wb_addr   = addr;
        bus.in_rf_wen    = wen;
        bus.in_alu_out   = alu;
        bus.in_mem_rdata = rdata;
        bus.in_mem_off   = off;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
        bus.rs1_addr = a;
        #1;
        chk(tag, {32'b0, bus.rs1_data}, {32'b0, exp});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_redir_vld", {63'b0, bus.redirect_valid}, 64'd0);
        chk("rst_instret",   bus.instret, 64'd0);
        chk("rst_exit",      {63'b0, bus.exit}, 64'd0);
        chk("rst_in_ready",  {63'b0, bus.in_ready}, 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b1;
        bus.rs1_addr = '0;
        bus.rs2_addr = '0;
        clear_inputs();
        @(posedge clk);
        #1;
        do_reset();

        rd(5'd0, 32'h0, "x0_rst");
        rd(5'd1, 32'h0, "x1_rst");
        rd(5'd2, 32'h0000_0800, "x2_rst");
        chk("rst_redir_pc", {32'b0, bus.redirect_pc}, 64'd0);

        // Sub-word loads
        drive(32'h1000, S_MEMB, 5'd5, 1'b1, 32'h0, 32'h12F4_5678, 2'd2);
        rd(5'd5, 32'hFFFF_FFF4, "memb_bypass");
        step();
        rd(5'd5, 32'hFFFF_FFF4, "memb_off2");
        drive(32'h1004, S_MEMHU, 5'd6, 1'b1, 32'h0, 32'h12F4_5678, 2'd2);
        step();
        rd(5'd6, 32'h0000_12F4, "memhu_off2");
        drive(32'h1008, S_MEMW, 5'd7, 1'b1, 32'h0, 32'h12F4_5678, 2'd3);
        step();
        rd(5'd7, 32'h12F4_5678, "memw_unshifted");
        drive(32'h100C, S_MEMBU, 5'd8, 1'b1, 32'h0, 32'h12F4_5678, 2'd1);
        step();
        rd(5'd8, 32'h0000_0056, "membu_off1");
        drive(32'h1010, S_MEMH, 5'd9, 1'b1, 32'h0, 32'h8001_7FFF, 2'd3);
        step();
        rd(5'd9, 32'hFFFF_8001, "memh_off3");
        drive(32'h1014, S_MEMH, 5'd9, 1'b1, 32'h0, 32'h8001_7FFF, 2'd0);
        step();
        rd(5'd9, 32'h0000_7FFF, "memh_off0");
        drive(32'h1018, S_MEMB, 5'd16, 1'b1, 32'h0, 32'h8001_7FFF, 2'd3);
        step();
        rd(5'd16, 32'hFFFF_FF80, "memb_off3");

        // x0 and bypass
        drive(32'h101C, S_ALU, 5'd0, 1'b1, 32'h0000_DEAD, 32'h0, 2'd0);
        rd(5'd0, 32'h0, "x0_no_bypass");
        step();
        rd(5'd0, 32'h0, "x0_write_ignored");
        drive(32'h1020, S_ALU, 5'd3, 1'b1, 32'h0000_BEEF, 32'h0, 2'd0);
        bus.rs2_addr = 5'd4;
        rd(5'd3, 32'h0000_BEEF, "rs1_bypass");
        chk("rs2_no_bypass", {32'b0, bus.rs2_data}, 64'd0);
        step();
        rd(5'd3, 32'h0000_BEEF, "x3_array");
        drive(32'h1024, S_ALU, 5'd4, 1'b0, 32'h0000_1234, 32'h0, 2'd0);
        step();
        rd(5'd4, 32'h0, "wen_low");
        drive(32'h1028, 4'd9, 5'd17, 1'b1, 32'h0000_A5A5, 32'h0, 2'd0);
        step();
        rd(5'd17, 32'h0000_A5A5, "sel9_alu");
        drive(32'h102C, S_CSR, 5'd18, 1'b1, 32'h0000_0001, 32'h0, 2'd0);
        bus.in_csr_rdata = 32'h0000_C5C5;
        step();
        rd(5'd18, 32'h0000_C5C5, "csr_sel");

        // PC+4 incl. wrap
        drive(32'h1030, S_ALU, 5'd10, 1'b1, 32'h0000_0099, 32'h0, 2'd0);
        step();
        drive(32'hFFFF_FFFC, S_PC4, 5'd10, 1'b1, 32'h0, 32'h0, 2'd0);
        step();
        rd(5'd10, 32'h0, "pc4_wrap");
        drive(32'h0000_1000, S_PC4, 5'd11, 1'b1, 32'h0, 32'h0, 2'd0);
        step();
        rd(5'd11, 32'h0000_1004, "pc4");

        // Redirect priority and pulse shape
        drive(32'h2000, S_ALU, 5'd0, 1'b0, 32'h0000_0200, 32'h0, 2'd0);
        bus.in_br_flg = 1'b1; bus.in_jmp_flg = 1'b1; bus.in_trap = 1'b1;
        bus.in_br_target = 32'h100; bus.in_trap_vector = 32'h300;
        #1;
        chk("redir_pre_edge", {63'b0, bus.redirect_valid}, 64'd0);
        step();
        chk("redir_br_vld", {63'b0, bus.redirect_valid}, 64'd1);
        chk("redir_br_pc",  {32'b0, bus.redirect_pc}, 64'h100);
        step();
        chk("redir_drop", {63'b0, bus.redirect_valid}, 64'd0);
        drive(32'h2004, S_ALU, 5'd0, 1'b0, 32'h0000_0200, 32'h0, 2'd0);
        bus.in_jmp_flg = 1'b1; bus.in_trap = 1'b1; bus.in_trap_vector = 32'h300;
        step();
        chk("redir_jmp_vld", {63'b0, bus.redirect_valid}, 64'd1);
        chk("redir_jmp_pc",  {32'b0, bus.redirect_pc}, 64'h200);
        drive(32'h2008, S_ALU, 5'd0, 1'b0, 32'h0000_0200, 32'h0, 2'd0);
        bus.in_trap = 1'b1; bus.in_trap_vector = 32'h300;
        step();
        chk("redir_b2b_vld", {63'b0, bus.redirect_valid}, 64'd1);
        chk("redir_trap_pc", {32'b0, bus.redirect_pc}, 64'h300);
        step();
        chk("redir_b2b_drop", {63'b0, bus.redirect_valid}, 64'd0);

        // Fields present but in_valid low: nothing retires
        drive(32'h3000, S_ALU, 5'd13, 1'b1, 32'h0000_0055, 32'h0, 2'd0);
        bus.in_valid = 1'b0;
        step();
        rd(5'd13, 32'h0, "idle_no_write");
        chk("instret_seg_a", bus.instret, 64'd18);

        // Exit: three retires, then the exit PC
        do_reset();
        drive(32'h10, S_ALU, 5'd20, 1'b1, 32'h1, 32'h0, 2'd0); step();
        drive(32'h14, S_ALU, 5'd21, 1'b1, 32'h2, 32'h0, 2'd0); step();
        drive(32'h18, S_ALU, 5'd22, 1'b1, 32'h3, 32'h0, 2'd0); step();
        drive(32'hFFFF_FF00, S_ALU, 5'd14, 1'b1, 32'h77, 32'h0, 2'd0);
        bus.in_jmp_flg = 1'b1;
        #1;
        chk("ready_before_exit", {63'b0, bus.in_ready}, 64'd1);
        step();
        chk("exit_instret",  bus.instret, 64'd4);
        chk("exit_flag",     {63'b0, bus.exit}, 64'd1);
        chk("exit_ready",    {63'b0, bus.in_ready}, 64'd0);
        chk("exit_redir",    {32'b0, bus.redirect_pc}, 64'h77);
        rd(5'd14, 32'h77, "exit_commit");
        drive(32'h2000, S_ALU, 5'd15, 1'b1, 32'h66, 32'h0, 2'd0);
        bus.in_br_flg = 1'b1; bus.in_br_target = 32'h500;
        step();
        rd(5'd15, 32'h0, "post_exit_no_write");
        chk("post_exit_instret", bus.instret, 64'd4);
        chk("post_exit_no_redir", {63'b0, bus.redirect_valid}, 64'd0);

        // Reset clears exit; then reset again while a redirect is pending
        do_reset();
        drive(32'h40, S_ALU, 5'd5, 1'b1, 32'h33, 32'h0, 2'd0);
        bus.in_br_flg = 1'b1; bus.in_br_target = 32'h400;
        step();
        chk("pending_redir", {63'b0, bus.redirect_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_redir_vld", {63'b0, bus.redirect_valid}, 64'd0);
        chk("async_redir_pc",  {32'b0, bus.redirect_pc}, 64'd0);
        chk("async_instret",   bus.instret, 64'd0);
        chk("async_exit",      {63'b0, bus.exit}, 64'd0);
        rd(5'd5, 32'h0, "async_x5");
        rd(5'd2, 32'h0000_0800, "async_x2");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_retire_unit.md
# wb_retire_unit

Parametrised write-back and retirement stage of the core pipeline, sitting after the memory stage. Accepts one completed instruction per cycle over a valid/ready handshake. Selects and sign-/zero-extends the write-back value, including sub-word load alignment, and commits it to an internal register file with x0 hard-wired to zero. Produces a registered one-cycle redirect for branches, jumps and traps, counts retired instructions, and raises a sticky exit flag that halts retirement.

## Interface
- XLEN, 32: datapath width (32 or 64).
- NREG, 32: architectural register count (power of two, ≥2).
- SP_INIT, 32'h00000800: reset value of x2.
- EXIT_PC, 32'hffffff00: retiring this PC sets exit.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  instruction presented.
- in_ready  out  1  stage accepts; equals !exit.
- in_pc  in  XLEN  PC of the instruction.
- in_wb_sel  in  4  0 ALU, 1 MEMB, 2 MEMBU, 3 MEMH, 4 MEMHU, 5 MEMW, 6 PC+4, 7 CSR; 8–15 treated as ALU.
- in_wb_addr  in  log2(NREG)  destination register.
- in_rf_wen  in  1  register write enable.
- in_alu_out  in  XLEN  ALU result, also jump target.
- in_mem_rdata  in  XLEN  raw aligned-word load data.
- in_mem_off  in  2  byte offset of load address within the word.
- in_csr_rdata  in  XLEN  CSR read data.
- in_br_flg / in_jmp_flg / in_trap  in  1 each  taken branch, jump, trap/ECALL/xRET.
- in_br_target / in_trap_vector  in  XLEN each  targets.
- rs1_addr, rs2_addr  in  log2(NREG)  read-port addresses.
- rs1_data, rs2_data  out  XLEN  combinational read data.
- redirect_valid  out  1  one-cycle redirect pulse.
- redirect_pc  out  XLEN  redirect target.
- instret  out  64  retired instruction count.
- exit  out  1  sticky halt flag.

## Operation
- Retire event: in_valid && in_ready on a rising edge.
- Load extraction: byte = in_mem_rdata >> (8*in_mem_off); MEMB/MEMBU use byte[7:0]; MEMH/MEMHU use byte[15:0] (in_mem_off[0] ignored); MEMW uses in_mem_rdata unshifted. B/H sign-extend, BU/HU zero-extend to XLEN.
- PC+4 computed modulo 2^XLEN (0xFFFFFFFC → 0x00000000).
- Register write on retire when in_rf_wen and in_wb_addr ≠ 0; x0 never written, always reads 0.
- Read ports: array contents; bypass: if a retire with write to a nonzero address matching rsN_addr occurs this cycle, rsN_data = wb_data.
- Redirect priority: branch > jump > trap. Target br_target, alu_out or trap_vector respectively; no redirect when none set.
- instret += 1 per retire, wraps at 2^64.
- exit set when a retire has in_pc == EXIT_PC; that instruction still commits its write, count and redirect. Once set, in_ready = 0 until reset.

## Timing
- Reset (rst_n low, asynchronous, any time including mid-redirect): all registers 0 except x2 = SP_INIT; redirect_valid 0, redirect_pc 0, instret 0, exit 0, in_ready 1.
- Register write visible in the array the cycle after retire; same-cycle visibility only via bypass.
- redirect_valid/redirect_pc registered: high exactly the cycle after the redirecting retire; deasserts next cycle unless another redirecting retire occurs (back-to-back pulses allowed).
- instret and exit update at the retire edge; exit drops in_ready combinationally from the next cycle.
- in_valid low: no state change apart from redirect_valid returning to 0.

## Test plan
- Reset then read x0, x1, x2 -> 0, 0, 0x00000800; instret 0, in_ready 1.
- Retire MEMB with in_mem_rdata 0x12F45678, off 2, wen, addr 5 -> x5 = 0xFFFFFFF4; MEMHU off 2 to x6 -> 0x000012F4; MEMW to x7 -> 0x12F45678.
- Retire ALU write 0xDEAD to x0 -> x0 reads 0; same-cycle write 0xBEEF to x3 with rs1_addr 3 -> rs1_data 0xBEEF combinationally.
- Retire with br_flg, jmp_flg, in_trap all set, br_target 0x100 -> next cycle redirect_valid 1, redirect_pc 0x100, then 0; in_pc 0xFFFFFFFC sel PC -> written value 0.
- Three retires then in_pc 0xFFFFFF00 -> instret 4, exit 1, in_ready 0; further in_valid ignored.
- Assert rst_n low the cycle a redirect is pending -> redirect_valid 0 immediately, instret 0, exit 0.
